// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth multiplier.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package booth_pkg;

  // Smallest operand width that still leaves a meaningful radix-4 iteration count
  localparam int MIN_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude of a radix-4 Booth digit
  typedef enum logic [1:0] {
    MAG_0 = 2'd0,
    MAG_1 = 2'd1,
    MAG_2 = 2'd2
  } mag_t;

  // Booth digit in {-2,-1,0,+1,+2}: sign flag plus magnitude
  typedef struct packed {
    logic neg;
    mag_t mag;
  } digit_t;

  // Two guard bits let unsigned operands ride through signed Booth arithmetic
  // and keep the iteration count integral for even N.
  function automatic int ext_width(input int n);
    return n + 2;
  endfunction

  function automatic int iter_count(input int n);
    return (n + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Recodes a Booth triplet into a digit and selects the matching partial product.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module booth_r4_recoder
  import booth_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [2:0]   triplet,
  input  logic [W-1:0] m_ext,
  output logic [W:0]   pp
);

  digit_t     digit;
  logic [W:0] sel;

  // Triplet {q1, q0, q-1} to signed digit
  always_comb begin
    digit = '{neg: 1'b0, mag: MAG_0};
    case (triplet)
      3'b001, 3'b010: digit = '{neg: 1'b0, mag: MAG_1};
      3'b011:         digit = '{neg: 1'b0, mag: MAG_2};
      3'b100:         digit = '{neg: 1'b1, mag: MAG_2};
      3'b101, 3'b110: digit = '{neg: 1'b1, mag: MAG_1};
      default:        digit = '{neg: 1'b0, mag: MAG_0};
    endcase
  end

  // Pick 0, M or 2M at W+1 bits, then negate by two's complement for negative digits
  always_comb begin
    sel = '0;
    case (digit.mag)
      MAG_1:   sel = {m_ext[W-1], m_ext};
      MAG_2:   sel = {m_ext, 1'b0};
      default: sel = '0;
    endcase
    pp = digit.neg ? (~sel + {{W{1'b0}}, 1'b1}) : sel;
  end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation, 2 bits per cycle.
// Latency: done pulses (N+2)/2+1 cycles after the accept cycle; result held until next accept.
// Backpressure: ready low while iterating; start is ignored then (no queueing).
module booth_r4_multiplier
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           is_signed,
  input  logic [N-1:0]   data_M,
  input  logic [N-1:0]   data_Q,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] data_out
);

  localparam int W     = ext_width(N);
  localparam int ITERS = iter_count(N);
  localparam int CNT_W = $clog2(ITERS);

  generate
    if (N < MIN_N || (N % 2) != 0) begin : g_bad_n
      $error("booth_r4_multiplier: N must be even and >= 4");
    end
  endgenerate

  state_t           state_q;
  state_t           state_d;
  logic [W:0]       a_q;
  logic [W-1:0]     q_q;
  logic             qm1_q;
  logic [W-1:0]     m_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2*N-1:0]   data_out_q;

  logic             accept;
  logic             last_iter;
  logic [W-1:0]     m_in_ext;
  logic [W-1:0]     q_in_ext;
  logic [W:0]       pp;
  logic [W:0]       a_sum;
  logic [2*W+1:0]   shifted;
  logic [W:0]       a_nxt;
  logic [W-1:0]     q_nxt;
  logic             qm1_nxt;

  assign ready     = (state_q != ITER);
  assign done      = (state_q == DONE);
  assign accept    = start & ready;
  assign last_iter = (state_q == ITER) && (cnt_q == CNT_W'(ITERS - 1));
  assign data_out  = data_out_q;

  // Widen incoming operands by two bits according to the requested signedness
  always_comb begin
    m_in_ext = {2'b00, data_M};
    q_in_ext = {2'b00, data_Q};
    if (is_signed) begin
      m_in_ext = {{2{data_M[N-1]}}, data_M};
      q_in_ext = {{2{data_Q[N-1]}}, data_Q};
    end
  end

  booth_r4_recoder #(
    .W (W)
  ) u_recoder (
    .triplet (({q_q[1:0], qm1_q})),
    .m_ext   (m_q),
    .pp      (pp)
  );

  // One iteration: accumulate the partial product, then arithmetic shift {A,Q,q-1} right by 2
  always_comb begin
    a_sum   = a_q + pp;
    shifted = {{2{a_sum[W]}}, a_sum, q_q[W-1:1]};
    a_nxt   = shifted[2*W+1:W+1];
    q_nxt   = shifted[W:1];
    qm1_nxt = shifted[0];
  end

  // Next-state: accept moves to ITER, last iteration moves to DONE, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ITER;
      ITER:    if (last_iter) state_d = DONE;
      DONE:    state_d = start ? ITER : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand load on accept, shift-accumulate while iterating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      q_q   <= '0;
      qm1_q <= 1'b0;
      m_q   <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q   <= '0;
      q_q   <= q_in_ext;
      qm1_q <= 1'b0;
      m_q   <= m_in_ext;
      cnt_q <= '0;
    end else if (state_q == ITER) begin
      a_q   <= a_nxt;
      q_q   <= q_nxt;
      qm1_q <= qm1_nxt;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Capture the low 2N product bits straight out of the final iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else if (last_iter) begin
      data_out_q <= {a_nxt[N-3:0], q_nxt};
    end
  end

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Bench for booth_r4_multiplier at N=4, 8 and 16 against an arithmetic reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_booth_r4_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_v = 3'b000;
  logic        is_signed = 1'b0;
  logic [15:0] m_in = '0;
  logic [15:0] q_in = '0;
  logic [2:0]  ready_v;
  logic [2:0]  done_v;
  logic [7:0]  out4;
  logic [15:0] out8;
  logic [31:0] out16;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  booth_r4_multiplier #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .is_signed(is_signed),
    .data_M(m_in[3:0]), .data_Q(q_in[3:0]),
    .ready(ready_v[0]), .done(done_v[0]), .data_out(out4)
  );

  booth_r4_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .is_signed(is_signed),
    .data_M(m_in[7:0]), .data_Q(q_in[7:0]),
    .ready(ready_v[1]), .done(done_v[1]), .data_out(out8)
  );

  booth_r4_multiplier #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .is_signed(is_signed),
    .data_M(m_in), .data_Q(q_in),
    .ready(ready_v[2]), .done(done_v[2]), .data_out(out16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int w);
    return (w == 0) ? 4 : ((w == 1) ? 8 : 16);
  endfunction

  function automatic logic [31:0] get_out(input int w);
    case (w)
      0:       return {24'b0, out4};
      1:       return {16'b0, out8};
      default: return out16;
    endcase
  endfunction

  // Plain integer product of the operands as interpreted in the chosen mode
  function automatic logic [31:0] ref_mul(input int n, input logic s,
                                          input logic [15:0] m, input logic [15:0] q);
    longint mask_n, mask_p, mi, qi, p;
    mask_n = (longint'(1) << n) - 1;
    mask_p = (longint'(1) << (2 * n)) - 1;
    mi = longint'(m) & mask_n;
    qi = longint'(q) & mask_n;
    if (s && mi[n-1]) mi = mi - (longint'(1) << n);
    if (s && qi[n-1]) qi = qi - (longint'(1) << n);
    p = (mi * qi) & mask_p;
    return p[31:0];
  endfunction

  // Present an operation at the current time, hold start across one rising edge
  task automatic issue(input int w, input logic s, input logic [15:0] m, input logic [15:0] q);
    is_signed  = s;
    m_in       = m;
    q_in       = q;
    start_v[w] = 1'b1;
    @(posedge clk);
    #1;
    start_v[w] = 1'b0;
    is_signed  = 1'($urandom);
    m_in       = 16'($urandom);
    q_in       = 16'($urandom);
  endtask

  // Count falling edges after the accept until done is seen (bounded)
  task automatic wait_done(input int w, output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done_v[w]) break;
    end
  endtask

  task automatic run_op(input int w, input logic s, input logic [15:0] m, input logic [15:0] q,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    issue(w, s, m, q);
    wait_done(w, lat);
    res = get_out(w);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] hold;
    int          lat;
    int          pulses;
    int          done_at;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready_v[1]), 32'd1);
    check("rst_done", 32'(done_v[1]), 32'd0);
    check("rst_out", get_out(1), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Signed small product with latency
    run_op(1, 1'b1, 16'h00F9, 16'h0003, res, lat);
    check("neg7x3_lat", 32'(lat), 32'd6);
    check("neg7x3", res, 32'hFFEB);
    @(negedge clk);
    check("done_single", 32'(done_v[1]), 32'd0);

    run_op(1, 1'b0, 16'h00FF, 16'h00FF, res, lat);
    check("ff_ff_u", res, 32'hFE01);
    run_op(1, 1'b1, 16'h00FF, 16'h00FF, res, lat);
    check("ff_ff_s", res, 32'h0001);
    run_op(1, 1'b1, 16'h0080, 16'h0080, res, lat);
    check("min_min_s", res, 32'h4000);
    run_op(1, 1'b1, 16'h0080, 16'h007F, res, lat);
    check("min_max_s", res, 32'hC080);

    // start while busy is dropped
    @(negedge clk);
    issue(1, 1'b0, 16'd12, 16'd10);
    @(negedge clk);
    check("busy_ready", 32'(ready_v[1]), 32'd0);
    is_signed  = 1'b1;
    m_in       = 16'h0055;
    q_in       = 16'h0033;
    start_v[1] = 1'b1;
    @(posedge clk);
    #1;
    start_v[1] = 1'b0;
    pulses  = 0;
    done_at = 0;
    res     = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done_v[1]) begin
        pulses++;
        if (pulses == 1) begin
          res     = get_out(1);
          done_at = i + 1;
        end
      end
    end
    check("ign_pulses", 32'(pulses), 32'd1);
    check("ign_lat", 32'(done_at), 32'd6);
    check("ign_res", res, 32'h0078);

    // Back-to-back: new start in the DONE cycle
    run_op(1, 1'b1, 16'h00FB, 16'h0007, res, lat);
    check("b2b_first", res, 32'hFFDD);
    check("b2b_ready", 32'(ready_v[1]), 32'd1);
    issue(1, 1'b0, 16'd200, 16'd3);
    wait_done(1, lat);
    check("b2b_lat", 32'(lat), 32'd6);
    check("b2b_second", get_out(1), 32'h0258);

    // Reset in the third iteration cycle aborts the operation
    @(negedge clk);
    issue(1, 1'b0, 16'd100, 16'd100);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready_v[1]), 32'd1);
    check("abort_done", 32'(done_v[1]), 32'd0);
    check("abort_out", get_out(1), 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_v[1]) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    run_op(1, 1'b0, 16'd5, 16'd5, res, lat);
    check("after_abort", res, 32'h0019);

    // Random sweep across widths, corners first
    for (int w = 0; w < 3; w++) begin
      int          n;
      logic [15:0] mask;
      n    = width_of(w);
      mask = 16'((32'd1 << n) - 1);
      for (int i = 0; i < 40; i++) begin
        logic        s;
        logic [15:0] m;
        logic [15:0] q;
        int          gap;
        s = 1'($urandom);
        m = 16'($urandom) & mask;
        q = 16'($urandom) & mask;
        if (i == 0) begin s = 1'b1; m = 16'(32'd1 << (n - 1)); q = m; end
        if (i == 1) begin s = 1'b0; m = mask; q = mask; end
        if (i == 2) begin m = '0; end
        run_op(w, s, m, q, res, lat);
        check($sformatf("rnd_n%0d_%0d_lat", n, i), 32'(lat), 32'((n + 2) / 2 + 1));
        check($sformatf("rnd_n%0d_%0d s=%0d m=%0h q=%0h", n, i, s, m, q), res, ref_mul(n, s, m, q));
        hold = res;
        gap  = $urandom_range(1, 3);
        repeat (gap) @(negedge clk);
        check($sformatf("rnd_n%0d_%0d_hold", n, i), get_out(w), hold);
        check($sformatf("rnd_n%0d_%0d_idle", n, i), 32'(done_v[w]), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/booth_r4_multiplier.md
Name: booth_r4_multiplier

Overview:
Parametrised sequential radix-4 (modified) Booth multiplier. It is the next generation of the team's radix-2 Booth multiplier top, which used a separate datapath and controller.
- Retires 2 multiplier bits per cycle.
- Supports signed and unsigned operands, selected per operation.
- Adds a ready/start handshake and an asynchronous active-low reset.
- Sits as an arithmetic slave behind a sequencer; the result is held until the next accepted start.

Parameters:
N, 8, operand width in bits; must be even and >=4 (elaboration-time check fails otherwise).
W (local), N+2, internal extended operand width.
ITERS (local), W/2, number of radix-4 iterations.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when ready=1
is_signed  input  1  1: two's-complement operands; 0: unsigned; sampled with start
data_M  input  N  multiplicand, sampled with start
data_Q  input  N  multiplier, sampled with start
ready  output  1  1 in IDLE and DONE; 0 while busy
done  output  1  single-cycle pulse when data_out becomes valid
data_out  output  2N  product; held stable from done until the next accepted start

Behaviour:
- Reset (async assert, sync release): state=IDLE, ready=1, done=0, data_out=0; all internal registers cleared.
- Reset asserted mid-operation aborts immediately. No done is produced for the aborted operation.
- States: IDLE, ITER, DONE.
  - IDLE --start--> ITER.
  - ITER --(cnt==ITERS-1)--> DONE.
  - DONE --start--> ITER.
  - DONE --!start--> IDLE.
- Accept edge k (start=1, ready=1):
  - M and Q are extended to W bits: sign-extended if is_signed, else zero-extended.
  - Accumulator A (W+1 bits) is cleared; Q_ext is loaded with appended bit q(-1)=0; cnt=0.
- ITER, one cycle per iteration:
  - Recode triplet {Q[1],Q[0],q(-1)} to a digit in {-2,-1,0,+1,+2}.
  - A += digit*M_ext, sign-extended to W+1 bits; -M and -2M are formed by two's complement.
  - Arithmetic shift right by 2 of {A,Q,q(-1)}; cnt++.
- Latency: ITER occupies edges k+1..k+ITERS. DONE is entered after edge k+ITERS, so done=1 in the cycle following edge k+ITERS.
  - Example: N=8 gives ITERS=5, so done is high in the 6th cycle after the accept cycle.
- data_out is the low 2N bits of the final {A,Q}. It is registered at the transition into DONE and is exact for every operand pair in either mode; the extension guarantees no overflow.
- done is high only in DONE, for exactly one cycle.
- start while ready=0 is ignored; no queueing.
- start in the DONE cycle is accepted: done pulses that cycle and the new operation begins at the same edge.
- is_signed, data_M and data_Q are don't-care except in the accept cycle.
- Boundary results:
  - Signed corner case (-2^(N-1)) x (-2^(N-1)) gives 2^(2N-2).
  - Unsigned (2^N-1)^2 is exact.
  - Zero operands produce 0.

Decomposition:
- Package booth_pkg:
  - state enum (IDLE/ITER/DONE);
  - Booth digit encoding type (sign bit plus magnitude {0,1,2});
  - localparam helpers for W and ITERS.
- Sub-module booth_r4_recoder: a combinational triplet-to-digit decoder plus a partial-product selector (0/M/2M with negate). It is instantiated once.
- The FSM, counter and shift registers live in the top.

Test Plan:
- N=8, is_signed=1, M=-7 (0xF9), Q=3 -> done exactly 6 cycles after accept; data_out=0xFFEB (-21).
- N=8, is_signed=0, M=0xFF, Q=0xFF -> data_out=0xFE01. Then is_signed=1 with the same operands -> data_out=0x0001.
- N=8, is_signed=1, M=0x80, Q=0x80 -> data_out=0x4000. Then M=0x80, Q=0x7F -> data_out=0xC080.
- Pulse start with new operands while ready=0 -> ignored; the original result is returned and done pulses once. Then assert start in the DONE cycle -> back-to-back result with no idle gap.
- Assert rst_n=0 during ITER cycle 3 -> ready=1, done=0, data_out=0 immediately. No done follows. A fresh 5x5 (is_signed=0) -> 0x0019.
- Randomised sweep for N=4, 8, 16 against a reference model, both modes -> every product exact; data_out is stable between done and the next accept.
